// File: rtl/ecb_pkg.sv
// Shared types and helpers for the ECB/CBC row cipher: FSM states, rotation constants, rotate functions.
package ecb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    DONE
  } state_t;

  localparam int unsigned ROT_AMT = 5;
  localparam int unsigned RK_STEP = 8;
  localparam int unsigned MAXW    = 256;

  // Rotate the low w bits of x left by n (mod w); bits above w are returned as zero.
  function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] x,
                                          input int unsigned     n,
                                          input int unsigned     w);
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] xm;
    int unsigned     s;
    s    = n % w;
    mask = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    xm   = x & mask;
    return ((xm << s) | (xm >> (w - s))) & mask;
  endfunction

  function automatic logic [MAXW-1:0] rotr(input logic [MAXW-1:0] x,
                                          input int unsigned     n,
                                          input int unsigned     w);
    return rotl(x, (w - (n % w)) % w, w);
  endfunction

endpackage

// File: rtl/ecb_block_cipher.sv
// Combinational per-block cipher: ROUNDS of key-mix and fixed rotation, or the exact inverse when decrypting.
module ecb_block_cipher
  import ecb_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned ROUNDS     = 4
) (
  input  logic [BLOCK_SIZE-1:0] data_i,
  input  logic [BLOCK_SIZE-1:0] key_i,
  input  logic                  decrypt_i,
  output logic [BLOCK_SIZE-1:0] data_o
);

  logic [BLOCK_SIZE-1:0] x;
  logic [BLOCK_SIZE-1:0] rk;
  int unsigned           r;

  always_comb begin
    x  = data_i;
    rk = '0;
    r  = 0;
    if (!decrypt_i) begin
      for (int unsigned k = 0; k < ROUNDS; k++) begin
        rk = BLOCK_SIZE'(rotl(MAXW'(key_i), (RK_STEP * k) % BLOCK_SIZE, BLOCK_SIZE));
        x  = BLOCK_SIZE'(rotl(MAXW'(x ^ rk), ROT_AMT, BLOCK_SIZE));
      end
    end else begin
      for (int unsigned k = 0; k < ROUNDS; k++) begin
        r  = ROUNDS - 1 - k;
        rk = BLOCK_SIZE'(rotl(MAXW'(key_i), (RK_STEP * r) % BLOCK_SIZE, BLOCK_SIZE));
        x  = BLOCK_SIZE'(rotr(MAXW'(x), ROT_AMT, BLOCK_SIZE)) ^ rk;
      end
    end
    data_o = x;
  end

endmodule

// File: rtl/ecb_row_cipher.sv
// Row-wide block cipher: accepts a packed row, ciphers one block per cycle, presents the row until consumed.
// Define ECB_ROW_CBC_EN to chain blocks within a row (CBC); default build is pure ECB.
module ecb_row_cipher
  import ecb_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned HSIZE      = 768,
  parameter int unsigned ROUNDS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HSIZE-1:0]      image_row,
  input  logic [BLOCK_SIZE-1:0] key,
  input  logic                  decrypt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HSIZE-1:0]      row_out,
  output logic                  busy
);

  localparam int unsigned NBLK = HSIZE / BLOCK_SIZE;
  localparam int unsigned IW   = $clog2(NBLK + 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [HSIZE-1:0]      row_in_q, row_in_d;
  logic [HSIZE-1:0]      row_out_q, row_out_d;
  logic [BLOCK_SIZE-1:0] key_q, key_d;
  logic [BLOCK_SIZE-1:0] res_q, res_d;
  logic                  dec_q, dec_d;
  logic [BLOCK_SIZE-1:0] blk_in, cip_in, cip_out, blk_res;

  ecb_block_cipher #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .ROUNDS    (ROUNDS)
  ) u_cipher (
    .data_i   (cip_in),
    .key_i    (key_q),
    .decrypt_i(dec_q),
    .data_o   (cip_out)
  );

`ifdef ECB_ROW_CBC_EN
  logic [BLOCK_SIZE-1:0] chain_q, chain_d;

  assign cip_in  = dec_q ? blk_in : (blk_in ^ chain_q);
  assign blk_res = dec_q ? (cip_out ^ chain_q) : cip_out;

  always_comb begin
    chain_d = chain_q;
    if (state_q == IDLE && in_valid) begin
      chain_d = '0;
    end else if (state_q == PROC && 32'(idx_q) < NBLK) begin
      chain_d = dec_q ? blk_in : cip_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end
`else
  assign cip_in  = blk_in;
  assign blk_res = cip_out;
`endif

  // Block i is ciphered into res_q while idx==i and lands in row_out on idx==i+1,
  // so PROC spans NBLK+1 cycles and out_valid rises NBLK+1 edges after the accept.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_in_d  = row_in_q;
    row_out_d = row_out_q;
    key_d     = key_q;
    dec_d     = dec_q;
    res_d     = res_q;
    blk_in    = '0;
    for (int unsigned b = 0; b < NBLK; b++) begin
      if (32'(idx_q) == b) blk_in = row_in_q[b*BLOCK_SIZE +: BLOCK_SIZE];
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          row_in_d = image_row;
          key_d    = key;
          dec_d    = decrypt;
          idx_d    = '0;
          state_d  = PROC;
        end
      end
      PROC: begin
        if (32'(idx_q) < NBLK) res_d = blk_res;
        for (int unsigned b = 0; b < NBLK; b++) begin
          if (32'(idx_q) == b + 1) row_out_d[b*BLOCK_SIZE +: BLOCK_SIZE] = res_q;
        end
        if (32'(idx_q) == NBLK) state_d = DONE;
        else                    idx_d   = idx_q + IW'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_in_q  <= '0;
      row_out_q <= '0;
      key_q     <= '0;
      dec_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_in_q  <= row_in_d;
      row_out_q <= row_out_d;
      key_q     <= key_d;
      dec_q     <= dec_d;
      res_q     <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign row_out   = row_out_q;

endmodule

// File: tb/tb_ecb_row_cipher.sv
// Self-checking bench for ecb_row_cipher against a word-level reference model of the row cipher.
module tb_ecb_row_cipher;

  localparam int unsigned BS    = 32;
  localparam int unsigned HSIZE = 768;
  localparam int unsigned NBLK  = HSIZE / BS;
  localparam int unsigned LAT   = NBLK + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [HSIZE-1:0] image_row;
  logic [BS-1:0]    key;
  logic             decrypt;
  logic             out_valid;
  logic             out_ready;
  logic [HSIZE-1:0] row_out;
  logic             busy;

  int               checks;
  int               errors;
  logic [HSIZE-1:0] exp_row;
  logic             exp_valid;

  ecb_row_cipher #(
    .BLOCK_SIZE(BS),
    .HSIZE     (HSIZE),
    .ROUNDS    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .image_row(image_row),
    .key      (key),
    .decrypt  (decrypt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .row_out  (row_out),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: rotations via a doubled word, rounds as plain loops.
  function automatic logic [31:0] rl(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} << (n % 32);
    return d[63:32];
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} >> (n % 32);
    return d[31:0];
  endfunction

  function automatic logic [31:0] enc_blk(input logic [31:0] p, input logic [31:0] k);
    logic [31:0] x;
    x = p;
    for (int r = 0; r < 4; r++) x = rl(x ^ rl(k, 8 * r), 5);
    return x;
  endfunction

  function automatic logic [31:0] dec_blk(input logic [31:0] c, input logic [31:0] k);
    logic [31:0] x;
    x = c;
    for (int r = 3; r >= 0; r--) x = rr(x, 5) ^ rl(k, 8 * r);
    return x;
  endfunction

  function automatic logic [HSIZE-1:0] model_row(input logic [HSIZE-1:0] row,
                                                  input logic [31:0]      k,
                                                  input logic             dec);
    logic [HSIZE-1:0] o;
    logic [31:0]      prev;
    logic [31:0]      blk;
    o    = '0;
    prev = '0;
    for (int i = 0; i < NBLK; i++) begin
      blk = row[i*BS +: BS];
`ifdef ECB_ROW_CBC_EN
      if (!dec) begin
        o[i*BS +: BS] = enc_blk(blk ^ prev, k);
        prev          = o[i*BS +: BS];
      end else begin
        o[i*BS +: BS] = dec_blk(blk, k) ^ prev;
        prev          = blk;
      end
`else
      o[i*BS +: BS] = dec ? dec_blk(blk, k) : enc_blk(blk, k);
`endif
    end
    return o;
  endfunction

  function automatic logic [HSIZE-1:0] rand_row();
    logic [HSIZE-1:0] r;
    for (int i = 0; i < NBLK; i++) r[i*BS +: BS] = $urandom;
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [HSIZE-1:0] act, input logic [HSIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: every presented row must be expected and match the model.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!exp_valid) begin
        chk1("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        chkw("row_out_vs_model", row_out, exp_row);
        chk1("in_ready_in_done", in_ready, 1'b0);
        chk1("busy_in_done", busy, 1'b1);
      end
    end
  end

  task automatic run_row(input logic [HSIZE-1:0] row, input logic [31:0] k, input logic dec,
                         input int hold, output logic [HSIZE-1:0] res);
    int               cnt;
    logic [HSIZE-1:0] held;
    exp_row   = model_row(row, k, dec);
    exp_valid = 1'b1;
    chk1("in_ready_before_accept", in_ready, 1'b1);
    image_row = row;
    key       = k;
    decrypt   = dec;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      in_valid  = 1'($urandom_range(0, 1));
      image_row = rand_row();
      key       = $urandom;
      decrypt   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cnt++;
    end
    chk32("latency", 32'(cnt), 32'(LAT));
    res  = row_out;
    held = row_out;
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'($urandom_range(0, 1));
      image_row = rand_row();
      @(posedge clk);
      #1;
      chkw("backpressure_hold", row_out, held);
      chk1("backpressure_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_valid = 1'b0;
    chk1("idle_after_release_valid", out_valid, 1'b0);
    chk1("idle_after_release_ready", in_ready, 1'b1);
    chk1("idle_after_release_busy", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [HSIZE-1:0] r0, c0, p0, res, vec;
    logic [31:0]      k0;
    checks    = 0;
    errors    = 0;
    exp_valid = 1'b0;
    exp_row   = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    image_row = '0;
    key       = '0;
    decrypt   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chkw("reset_row_out", row_out, '0);
    rst = 1'b0;

    // Model pins against hand-computed values.
    chk32("pin_rl8", rl(32'h1234_5678, 8), 32'h3456_7812);
    chk32("pin_enc_one", enc_blk(32'h0000_0001, 32'h0), 32'h0010_0000);
    chk32("pin_dec_one", dec_blk(32'h0010_0000, 32'h0), 32'h0000_0001);

    // Single-bit vector with zero key.
    vec = '0;
    vec[0] = 1'b1;
    run_row(vec, 32'h0, 1'b0, 0, res);
    chk32("vec_block0", res[31:0], 32'h0010_0000);
`ifndef ECB_ROW_CBC_EN
    chkw("vec_other_blocks", res >> BS, '0);
`endif

`ifdef ECB_ROW_CBC_EN
    for (int i = 0; i < NBLK; i++) vec[i*BS +: BS] = 32'h0000_0001;
    run_row(vec, 32'h0, 1'b0, 0, res);
    chk32("cbc_block0", res[31:0], 32'h0010_0000);
    chk32("cbc_block1", res[63:32], 32'h0010_0100);
`endif

    // Round trip with the fixed key.
    k0 = 32'hA5C3_1F07;
    r0 = rand_row();
    run_row(r0, k0, 1'b0, 0, c0);
    run_row(c0, k0, 1'b1, 0, p0);
    chkw("round_trip", p0, r0);

    // Backpressure for 10 cycles in DONE.
    run_row(rand_row(), $urandom, 1'b0, 10, res);

    // Abort at PROC index 7.
    exp_valid = 1'b0;
    image_row = rand_row();
    key       = $urandom;
    decrypt   = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk1("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chkw("abort_row_out", row_out, '0);
    repeat (30) @(posedge clk);
    #1;
    chk1("abort_still_idle", in_ready, 1'b1);
    run_row(r0, k0, 1'b0, 0, res);
    chkw("after_abort_result", res, c0);

    // Random rows, keys and directions.
    for (int n = 0; n < 6; n++) begin
      run_row(rand_row(), $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
